// File: rtl/legv8_datapath_ts_if.sv
// Control/observation bundle for the LEGv8 datapath: control word and immediate in,
// address, flags, IR and low register views out. The shared data bus stays a plain inout port.
interface legv8_datapath_ts_if;
    logic [39:0] ControlWord;
    logic [63:0] constant;
    logic [31:0] address;
    logic [4:0]  status;
    logic [31:0] IR_out;
    logic [3:0]  current_status;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;

    modport master (
        output ControlWord, constant,
        input  address, status, IR_out, current_status,
        input  r0, r1, r2, r3, r4, r5, r6, r7
    );

    modport slave (
        input  ControlWord, constant,
        output address, status, IR_out, current_status,
        output r0, r1, r2, r3, r4, r5, r6, r7
    );
endinterface

// File: rtl/legv8_datapath_ts.sv
// Single-cycle LEGv8 datapath: 32x64 register file, function-select ALU, 256-word RAM,
// PC and IR, all steered by one 40-bit control word per cycle over a shared tri-state bus.
module legv8_datapath_ts (
    input  logic               clock,
    input  logic               reset,
    inout  wire  [63:0]        data,
    legv8_datapath_ts_if.slave bus
);
    logic [4:0] sb, sa, da, fs;
    logic       rw, mw, c0, sl, il, bs, as_pc, pe;
    logic [1:0] ps, ds;

    assign sb    = bus.ControlWord[4:0];
    assign sa    = bus.ControlWord[9:5];
    assign da    = bus.ControlWord[14:10];
    assign rw    = bus.ControlWord[15];
    assign mw    = bus.ControlWord[16];
    assign c0    = bus.ControlWord[19];
    assign fs    = bus.ControlWord[24:20];
    assign sl    = bus.ControlWord[25];
    assign il    = bus.ControlWord[26];
    assign bs    = bus.ControlWord[27];
    assign as_pc = bus.ControlWord[28];
    assign ps    = bus.ControlWord[30:29];
    assign ds    = bus.ControlWord[32:31];
    assign pe    = bus.ControlWord[33];

    // Size field is fixed at doubleword and the top bits are spare.
    logic unused_cw;
    assign unused_cw = ^{bus.ControlWord[39:34], bus.ControlWord[18:17]};

    logic [63:0] regs [0:30];
    logic [63:0] mem  [0:255];
    logic [63:0] pc;
    logic [31:0] ir;
    logic [3:0]  cur_status;

    logic [63:0] reg_a, reg_b, b_sel, a_op, b_op, alu_y, mem_rd;
    logic [64:0] sum;
    logic        flag_v, flag_c;
    logic        drive_en;
    logic [63:0] bus_val, wr_data;

    assign reg_a = (sa == 5'd31) ? 64'd0 : regs[sa];
    assign reg_b = (sb == 5'd31) ? 64'd0 : regs[sb];

    always_comb begin
        b_sel  = bs ? bus.constant : reg_b;
        a_op   = fs[1] ? ~reg_a : reg_a;
        b_op   = fs[0] ? ~b_sel : b_sel;
        sum    = {1'b0, a_op} + {1'b0, b_op} + {64'd0, c0};
        alu_y  = 64'd0;
        flag_c = 1'b0;
        flag_v = 1'b0;
        case (fs[4:2])
            3'b000: alu_y = a_op & b_op;
            3'b001: alu_y = a_op | b_op;
            3'b010: begin
                alu_y  = sum[63:0];
                flag_c = sum[64];
                flag_v = (a_op[63] == b_op[63]) && (sum[63] != a_op[63]);
            end
            3'b011: alu_y = a_op ^ b_op;
            // Shift distance comes from the uninverted B operand.
            3'b100: alu_y = a_op << b_sel[5:0];
            3'b101: alu_y = a_op >> b_sel[5:0];
            default: alu_y = 64'd0;
        endcase
    end

    assign bus.status  = {reg_a == 64'd0, flag_v, flag_c, alu_y[63], alu_y == 64'd0};
    assign bus.address = as_pc ? pc[31:0] : alu_y[31:0];
    assign mem_rd      = mem[bus.address[10:3]];

    always_comb begin
        drive_en = 1'b1;
        bus_val  = alu_y;
        if (pe) begin
            bus_val = pc;
        end else begin
            case (ds)
                2'b00: bus_val = alu_y;
                2'b01: bus_val = reg_b;
                2'b11: bus_val = mem_rd;
                default: begin
                    drive_en = 1'b0;
                    bus_val  = 64'd0;
                end
            endcase
        end
    end

    // Internal writes take the value we drive, or the external value when released.
    assign data    = drive_en ? bus_val : 64'bz;
    assign wr_data = drive_en ? bus_val : data;

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc         <= 64'd0;
            ir         <= 32'd0;
            cur_status <= 4'd0;
            for (int i = 0; i < 31; i++) begin
                regs[i] <= 64'd0;
            end
        end else begin
            if (rw && (da != 5'd31)) begin
                regs[da] <= wr_data;
            end
            if (il) begin
                ir <= wr_data[31:0];
            end
            if (sl) begin
                cur_status <= bus.status[3:0];
            end
            case (ps)
                2'b01:   pc <= pc + 64'd4;
                2'b10:   pc <= reg_a;
                2'b11:   pc <= pc + bus.constant;
                default: pc <= pc;
            endcase
        end
    end

    // RAM contents survive reset; only the write itself is suppressed.
    always_ff @(posedge clock) begin
        if (reset && mw) begin
            mem[bus.address[10:3]] <= wr_data;
        end
    end

    assign bus.IR_out         = ir;
    assign bus.current_status = cur_status;
    assign bus.r0 = regs[0][15:0];
    assign bus.r1 = regs[1][15:0];
    assign bus.r2 = regs[2][15:0];
    assign bus.r3 = regs[3][15:0];
    assign bus.r4 = regs[4][15:0];
    assign bus.r5 = regs[5][15:0];
    assign bus.r6 = regs[6][15:0];
    assign bus.r7 = regs[7][15:0];
endmodule

// File: tb/tb_legv8_datapath_ts.sv
// Directed bench for legv8_datapath_ts: a table of control words with hand-computed
// expectations, followed by reset-priority and memory-retention sequences.
module tb_legv8_datapath_ts;
    logic        clock;
    logic        reset;
    logic        ext_en;
    logic [63:0] ext_val;
    wire  [63:0] data;

    legv8_datapath_ts_if dp_if ();

    assign data = ext_en ? ext_val : 64'bz;

    legv8_datapath_ts dut (
        .clock (clock),
        .reset (reset),
        .data  (data),
        .bus   (dp_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef enum int {K_NONE, K_REG, K_ADDR, K_STAT, K_IR, K_CS} kind_t;

    typedef struct {
        string       name;
        logic [39:0] cw;
        logic [63:0] cst;
        logic        ext_en;
        logic [63:0] ext_val;
        kind_t       pre_k;
        int          pre_i;
        logic [63:0] pre_e;
        kind_t       post_k;
        int          post_i;
        logic [63:0] post_e;
    } vec_t;

    localparam logic [39:0] RW   = 40'h1 << 15;
    localparam logic [39:0] MW   = 40'h1 << 16;
    localparam logic [39:0] SIZE = 40'h3 << 17;
    localparam logic [39:0] C0   = 40'h1 << 19;
    localparam logic [39:0] SL   = 40'h1 << 25;
    localparam logic [39:0] IL   = 40'h1 << 26;
    localparam logic [39:0] BS   = 40'h1 << 27;
    localparam logic [39:0] AS   = 40'h1 << 28;
    localparam logic [39:0] PE   = 40'h1 << 33;

    function automatic logic [39:0] f_sb(input logic [4:0] x); return {35'd0, x}; endfunction
    function automatic logic [39:0] f_sa(input logic [4:0] x); return {30'd0, x, 5'd0}; endfunction
    function automatic logic [39:0] f_da(input logic [4:0] x); return {25'd0, x, 10'd0}; endfunction
    function automatic logic [39:0] f_fs(input logic [4:0] x); return {15'd0, x, 20'd0}; endfunction
    function automatic logic [39:0] f_ps(input logic [1:0] x); return {9'd0, x, 29'd0}; endfunction
    function automatic logic [39:0] f_ds(input logic [1:0] x); return {7'd0, x, 31'd0}; endfunction

    int   n_total = 0;
    int   n_bad   = 0;
    vec_t vecs[$];

    function automatic logic [63:0] reg_val(input int idx);
        case (idx)
            0: return {48'd0, dp_if.r0};
            1: return {48'd0, dp_if.r1};
            2: return {48'd0, dp_if.r2};
            3: return {48'd0, dp_if.r3};
            4: return {48'd0, dp_if.r4};
            5: return {48'd0, dp_if.r5};
            6: return {48'd0, dp_if.r6};
            default: return {48'd0, dp_if.r7};
        endcase
    endfunction

    task automatic check_output(input string tag, input kind_t k, input int idx, input logic [63:0] exp);
        logic [63:0] act;
        string       what;
        act  = 64'd0;
        what = "";
        case (k)
            K_REG:  begin act = reg_val(idx); what = $sformatf("r%0d", idx); end
            K_ADDR: begin act = {32'd0, dp_if.address}; what = "address"; end
            K_STAT: begin act = {59'd0, dp_if.status}; what = "status"; end
            K_IR:   begin act = {32'd0, dp_if.IR_out}; what = "IR_out"; end
            K_CS:   begin act = {60'd0, dp_if.current_status}; what = "current_status"; end
            default: what = "";
        endcase
        if (k != K_NONE) begin
            n_total++;
            if (act !== exp) begin
                n_bad++;
                $display("[TB] FAIL %s %s: got %h expected %h", tag, what, act, exp);
            end
        end
    endtask

    task automatic add(input string name, input logic [39:0] cw, input logic [63:0] cst,
                       input logic xe, input logic [63:0] xv,
                       input kind_t pk, input int pi, input logic [63:0] pe_,
                       input kind_t qk, input int qi, input logic [63:0] qe);
        vec_t v;
        v.name = name; v.cw = cw | SIZE; v.cst = cst; v.ext_en = xe; v.ext_val = xv;
        v.pre_k = pk; v.pre_i = pi; v.pre_e = pe_;
        v.post_k = qk; v.post_i = qi; v.post_e = qe;
        vecs.push_back(v);
    endtask

    // Drive at the falling edge, check combinational outputs before the rising edge
    // and registered results just after it.
    task automatic apply_stimulus(input vec_t v);
        @(negedge clock);
        dp_if.ControlWord = v.cw;
        dp_if.constant    = v.cst;
        ext_en            = v.ext_en;
        ext_val           = v.ext_val;
        #1;
        check_output({v.name, "_pre"}, v.pre_k, v.pre_i, v.pre_e);
        @(posedge clock);
        #1;
        check_output({v.name, "_post"}, v.post_k, v.post_i, v.post_e);
        ext_en = 1'b0;
    endtask

    initial begin
        vec_t ld;

        reset             = 1'b0;
        ext_en            = 1'b0;
        ext_val           = 64'd0;
        dp_if.ControlWord = SIZE | AS;
        dp_if.constant    = 64'd24;

        repeat (2) @(posedge clock);
        #1;
        check_output("rst", K_ADDR, 0, 64'd0);
        check_output("rst", K_IR,   0, 64'd0);
        check_output("rst", K_CS,   0, 64'd0);
        check_output("rst", K_REG,  0, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        add("t1_or",     f_fs(5'b00100) | BS | f_sa(31) | f_da(0) | RW, 64'd24, 0, 0,
            K_STAT, 0, 64'h10, K_REG, 0, 64'd24);
        add("t2_sub",    f_fs(5'b01001) | C0 | f_sa(31) | f_sb(0) | f_da(1) | RW | SL, 64'd24, 0, 0,
            K_STAT, 0, 64'h12, K_CS, 0, 64'h2);
        add("t2_hold",   40'd0, 64'd24, 0, 0,
            K_REG, 1, 64'hFFE8, K_CS, 0, 64'h2);
        add("t3_store",  f_fs(5'b01000) | BS | f_sa(31) | f_sb(1) | MW | f_ds(2'b01), 64'd24, 0, 0,
            K_ADDR, 0, 64'd24, K_NONE, 0, 0);
        add("t3_load",   f_fs(5'b01000) | BS | f_sa(31) | f_ds(2'b11) | f_da(2) | RW, 64'd24, 0, 0,
            K_ADDR, 0, 64'd24, K_REG, 2, 64'hFFE8);
        add("t4_and",    f_fs(5'b00000) | f_sa(0) | f_sb(1) | f_da(1) | RW, 64'd24, 0, 0,
            K_STAT, 0, 64'h00, K_REG, 1, 64'd8);
        add("t5_inc_a",  AS | f_ps(2'b01), 64'd24, 0, 0, K_ADDR, 0, 64'd0, K_ADDR, 0, 64'd4);
        add("t5_inc_b",  AS | f_ps(2'b01), 64'd24, 0, 0, K_ADDR, 0, 64'd4, K_ADDR, 0, 64'd8);
        add("t5_rel",    AS | f_ps(2'b11), 64'd24, 0, 0, K_ADDR, 0, 64'd8, K_ADDR, 0, 64'd32);
        add("t5_ir",     AS | IL | f_ds(2'b01) | f_sb(1), 64'd24, 0, 0,
            K_ADDR, 0, 64'd32, K_IR, 0, 64'd8);
        add("add_ovf",   f_fs(5'b01000) | f_sa(1) | BS, 64'h7FFF_FFFF_FFFF_FFF8, 0, 0,
            K_STAT, 0, 64'h0A, K_NONE, 0, 0);
        add("add_carry", f_fs(5'b01000) | f_sa(1) | BS, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0,
            K_STAT, 0, 64'h05, K_NONE, 0, 0);
        add("shr",       f_fs(5'b10100) | f_sa(1) | BS | f_da(3) | RW, 64'd3, 0, 0,
            K_STAT, 0, 64'h00, K_REG, 3, 64'd1);
        add("shl",       f_fs(5'b10000) | f_sa(1) | BS | f_da(4) | RW, 64'd4, 0, 0,
            K_STAT, 0, 64'h00, K_REG, 4, 64'h80);
        add("xor",       f_fs(5'b01100) | f_sa(1) | BS | f_da(5) | RW, 64'hFF, 0, 0,
            K_NONE, 0, 0, K_REG, 5, 64'hF7);
        add("zero_op",   f_fs(5'b11000) | f_sa(1) | BS, 64'hFF, 0, 0,
            K_STAT, 0, 64'h01, K_NONE, 0, 0);
        add("r31_wr",    f_fs(5'b00100) | f_sa(31) | BS | f_da(31) | RW, 64'd5, 0, 0,
            K_STAT, 0, 64'h10, K_NONE, 0, 0);
        add("r31_rd",    f_fs(5'b00100) | f_sa(31) | BS, 64'd0, 0, 0,
            K_STAT, 0, 64'h11, K_NONE, 0, 0);
        add("ext_bus",   f_ds(2'b10) | f_da(6) | RW, 64'd24, 1, 64'h1234,
            K_NONE, 0, 0, K_REG, 6, 64'h1234);
        add("pc_bus",    PE | f_ds(2'b10) | f_da(7) | RW, 64'd24, 0, 0,
            K_NONE, 0, 0, K_REG, 7, 64'h20);
        add("pc_from_a", AS | f_ps(2'b10) | f_sa(1), 64'd24, 0, 0,
            K_ADDR, 0, 64'd32, K_ADDR, 0, 64'd8);
        add("nota_and",  f_fs(5'b00010) | f_sa(1) | BS | f_da(3) | RW, 64'hFF, 0, 0,
            K_NONE, 0, 0, K_REG, 3, 64'hF7);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
        end

        // Reset with every write enabled: nothing but the reset may land.
        @(negedge clock);
        reset             = 1'b0;
        dp_if.ControlWord = SIZE | f_fs(5'b01000) | BS | f_sa(31) | f_sb(1) | MW | f_ds(2'b01)
                          | RW | f_da(0) | IL | SL | f_ps(2'b01);
        dp_if.constant    = 64'd24;
        @(negedge clock);
        reset             = 1'b1;
        dp_if.ControlWord = SIZE | AS;
        #1;
        check_output("t6", K_ADDR, 0, 64'd0);
        check_output("t6", K_IR,   0, 64'd0);
        check_output("t6", K_CS,   0, 64'd0);
        for (int r = 0; r < 8; r++) begin
            check_output("t6", K_REG, r, 64'd0);
        end

        ld = vecs[4];
        ld.name = "t6_load";
        apply_stimulus(ld);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/legv8_datapath_ts.md
LEGV8_DATAPATH_TS -- requirements
Module: legv8_datapath_ts

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low; sampled on the rising clock edge.
REQ-004 ControlWord  in  40  per-cycle control word (fields in REQ-010).
REQ-005 data  inout  64  shared data bus; driven by DUT when an internal source is selected, otherwise high-Z.
REQ-006 constant  in  64  immediate operand.
REQ-007 address  out  32  memory address, low 32 bits of the selected address source.
REQ-008 status  out  5  combinational {Azero, V, C, N, Z}; the four ALU flags come from the current ALU operation.
REQ-009 IR_out 32, current_status 4 ({V,C,N,Z} latched), r0..r7 16 each (R0..R7 bits [15:0]); all outputs.

Function
REQ-010 ControlWord fields:
- SB [4:0]; SA [9:5]; DA [14:10]; RW [15] register write; MW [16] memory write.
- [18:17] size, always 11 (doubleword), otherwise ignored; C0 [19] ALU carry-in; FS [24:20]; SL [25] status load; IL [26] IR load.
- BS [27]: ALU B operand = constant when 1, register B when 0.
- AS [28]: address source = PC when 1, ALU result when 0.
- PS [30:29]: PC select; DS [32:31]: bus source; PE [33]: PC drives bus; [39:34] ignored.
REQ-011 Register file: 32 x 64 bits, two asynchronous read ports (A=SA, B=SB), one synchronous write port (DA, when RW=1). R31 always reads 0; writes to R31 are discarded.
REQ-012 Register write data SHALL be the data-bus value in that cycle.
REQ-013 ALU:
- Operands are A'=FS[1]?~A:A and B'=FS[0]?~Bop:Bop.
- FS[4:2] selects: 000 AND, 001 OR, 010 A'+B'+C0 (64-bit), 011 XOR, 100 A' << Bop[5:0], 101 A' >> Bop[5:0] (logical), 110/111 result 0.
REQ-014 Flags:
- Z = result==0; N = result[63].
- C = carry-out and V = signed overflow for op 010; C=V=0 otherwise.
- Azero = (register A == 0).
REQ-015 Data bus source:
- PE=1: PC drives the bus, DS ignored.
- PE=0, DS 00: ALU result; 01: register B; 11: memory read data; 10: DUT tri-states and the bus carries the external data value.
REQ-016 Memory: internal 256 x 64-bit RAM, indexed by address[10:3]. Read is asynchronous. On a rising edge with MW=1, RAM[address[10:3]] <= data bus value. Memory is not cleared by reset.
REQ-017 PC: 64-bit register.
- PS 00 hold; 01 PC+4; 10 PC <- register A; 11 PC <- PC + constant.
- Wrap modulo 2^64.
REQ-018 IR: 32-bit register; when IL=1, IR <= data bus[31:0] on the rising edge; otherwise hold.
REQ-019 current_status <= {V,C,N,Z} on the rising edge when SL=1; otherwise hold.
REQ-020 Simultaneous events: RW, MW, IL, SL and the PC update all take effect on the same edge, using values present before that edge. A read of a register being written returns the old value in that cycle.

Reset
REQ-021 When reset=0 at a rising edge: PC, IR, current_status and R0..R30 become 0. Reset takes priority over every ControlWord action in that cycle.
REQ-022 After reset the outputs are: address=0 (when AS=1), IR_out=0, current_status=0, r0..r7=0.
REQ-023 Reset asserted mid-sequence discards that cycle's register, memory, IR and PC writes.

Verification (constant=24, reset released)
REQ-024 Test 1: FS=00100, BS=1, SA=31, DA=0, RW=1, DS=00 -> r0=24.
REQ-025 Test 2: FS=01001, C0=1, SA=31, SB=0, DA=1, RW=1 -> r1=16'hFFE8. With SL=1, current_status = {V0,C0,N1,Z0}.
REQ-026 Test 3: store with FS=01000, BS=1, SA=31, SB=1, MW=1, DS=01. Then load with DS=11, DA=2, RW=1 -> r2=16'hFFE8.
REQ-027 Test 4: FS=00000, SA=0, SB=1, DA=1, RW=1 -> r1=8.
REQ-028 Test 5: AS=1, PS=01 for two cycles -> address 0, then 4, then 8. PS=11 -> address = prior PC+24. IL=1, DS=01, SB=1 -> IR_out = R1[31:0].
REQ-029 Test 6: reset=0 for one edge after the above -> address=0, r0..r7=0, IR_out=0. Then repeat test 3's load -> r2=16'hFFE8, since memory is retained across reset.
